// File: rtl/mag_gain_comp_if.sv
// Sample/result bundle for the CORDIC magnitude gain compensator.
interface mag_gain_comp_if #(
  parameter int OUT_W = 16
) ();
  logic             in_valid;
  logic [23:0]      mag_in;
  logic             flush;
  logic             peak_clr;
  logic             out_valid;
  logic [OUT_W-1:0] mag_out;
  logic [OUT_W-1:0] peak_out;
  logic             sat_flag;

  modport master (
    output in_valid, mag_in, flush, peak_clr,
    input  out_valid, mag_out, peak_out, sat_flag
  );

  modport slave (
    input  in_valid, mag_in, flush, peak_clr,
    output out_valid, mag_out, peak_out, sat_flag
  );
endinterface

// File: rtl/mag_gain_comp.sv
// Removes CORDIC gain from the final vectoring magnitude, rounds/saturates to OUT_W bits,
// with peak-hold and sticky saturation; fixed 3-clk latency, full rate, no backpressure.
module mag_gain_comp #(
  parameter int K_COEF = 159188,
  parameter int SHIFT  = 7,
  parameter int OUT_W  = 16
) (
  input  logic          clk,
  input  logic          reset_b,
  mag_gain_comp_if.slave bus
);

  localparam logic [17:0] K    = 18'(K_COEF);
  localparam logic [41:0] RND  = 42'd1 << (17 + SHIFT);
  localparam logic [41:0] MAXV = (42'd1 << OUT_W) - 42'd1;

  logic [2:0]       vld;
  logic [22:0]      s1_dat;
  logic [40:0]      s2_dat;
  logic [OUT_W-1:0] mag_q;
  logic [OUT_W-1:0] peak_q;
  logic             sat_q;

  logic [41:0]      rnd_sum;
  logic [41:0]      r;
  logic             sat_next;
  logic [OUT_W-1:0] mag_next;
  logic             load3;

  always_comb begin
    rnd_sum  = {1'b0, s2_dat} + RND;
    r        = rnd_sum >> (18 + SHIFT);
    sat_next = (r > MAXV);
    mag_next = sat_next ? {OUT_W{1'b1}} : r[OUT_W-1:0];
    // A flush on the same edge kills the sample reaching the output stage.
    load3    = vld[1] & ~bus.flush;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      vld    <= '0;
      s1_dat <= '0;
      s2_dat <= '0;
      mag_q  <= '0;
      peak_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      vld <= {vld[1], vld[0], bus.in_valid} & {3{~bus.flush}};

      if (bus.in_valid && !bus.flush)
        s1_dat <= bus.mag_in[23] ? 23'd0 : bus.mag_in[22:0];

      if (vld[0] && !bus.flush)
        s2_dat <= 41'(s1_dat) * 41'(K);

      if (load3)
        mag_q <= mag_next;

      // Clearing coincident with a completing sample restarts from that sample.
      if (bus.peak_clr) begin
        peak_q <= load3 ? mag_next : '0;
        sat_q  <= load3 & sat_next;
      end else if (load3) begin
        if (mag_next > peak_q)
          peak_q <= mag_next;
        if (sat_next)
          sat_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = vld[2];
  assign bus.mag_out   = mag_q;
  assign bus.peak_out  = peak_q;
  assign bus.sat_flag  = sat_q;

endmodule
